mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between two requesters: instruction fetch (IF) and data load/store (DM).
- Sits between the instruction-fetch stage / load-store unit and the memory block.
- Sequences each access with a request/ack handshake, holds memory-side signals stable until the memory signals ready, and aborts stalled accesses with a watchdog.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 32, memory data width
TIMEOUT_CYC, 255, max ACCESS cycles waiting for mem_ready before abort (1..255; 8-bit counter)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held until if_ack
if_addr  input  ADDR_W  fetch address
if_ack  output  1  one-cycle completion pulse for fetch
if_rdata  output  DATA_W  fetched instruction word
dm_req  input  1  data request; held until dm_ack
dm_rw  input  1  0=read, 1=write
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_ack  output  1  one-cycle completion pulse for data
dm_rdata  output  DATA_W  load data
err_out  output  1  one-cycle pulse with ack when access timed out
mem_en  output  1  memory access strobe
mem_rw_out  output  1  0=read, 1=write
mem_address_out  output  ADDR_W  memory address
mem_data_out  output  DATA_W  memory write data
mem_data_in  input  DATA_W  memory read data
mem_ready  input  1  memory completes current access this cycle

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0 (mem_rw_out=0 read); timeout counter=0; last-grant=IF.
- All outputs are registered.
- States:
  - IDLE: sample if_req/dm_req; on any request, pick winner, register address/rw/wdata into mem_* outputs, set mem_en=1 -> ACCESS. IF accesses always drive mem_rw_out=0. No request -> stay IDLE, mem_en=0.
  - ACCESS: mem_* outputs held stable; counter increments each cycle.
    - On mem_ready=1: capture mem_data_in into winner's rdata (reads only), mem_en=0, ack=1 next cycle -> DONE.
    - If counter reaches TIMEOUT_CYC with mem_ready still 0: mem_en=0, rdata=0 for reads, ack=1 and err_out=1 -> DONE.
    - mem_ready takes priority over timeout when both occur in the same cycle.
  - DONE: ack (and err_out if set) high exactly this cycle; requests not sampled -> IDLE; counter cleared.
- Latency:
  - Request seen in IDLE cycle N -> mem_en=1 in N+1.
  - mem_ready in cycle M -> ack in M+1.
  - Minimum req-to-ack is 2 cycles; back-to-back throughput is one access per 3 cycles.
- rdata outputs hold their last value until the next completed read for that requester. Writes never change dm_rdata.
- A request deasserted mid-transaction still completes and still acks. Requesters must drop req on the edge where they see ack, or a new access follows.
- mem_ready outside ACCESS is ignored.
- Arbitration on simultaneous requests (default): DM wins. A single request is granted immediately.
- Reset mid-access aborts without ack; all outputs return to 0.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin on ties. The requester not granted last wins. last-grant resets to IF, so DM wins the first tie. last-grant updates on every grant.
- Undefined: fixed DM-over-IF priority; no last-grant register.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - grant enum {GNT_IF, GNT_DM}
  - RW_READ=0, RW_WRITE=1
  - default ADDR_W/DATA_W constants
- One sub-module: mem_arb_timer (8-bit clear/increment counter with terminal-count compare against TIMEOUT_CYC).

Test Plan:
- IF read at 0x0010, mem_ready in first ACCESS cycle, mem_data_in=0x8C220004 -> mem_en/mem_rw_out=0/mem_address_out=0x0010 at N+1; if_ack=1, if_rdata=0x8C220004 at N+2.
- DM write at 0x0100 with wdata 0xCAFEF00D, mem_ready after 3 wait cycles -> mem_rw_out=1, mem_data_out=0xCAFEF00D held stable all 4 ACCESS cycles; dm_ack one cycle; dm_rdata unchanged.
- Both requesters assert the same cycle, default build -> DM served first, then IF after DM's DONE; 6 cycles total. With MEM_ARB_RR_EN and both held continuously -> grants alternate DM, IF, DM, IF.
- mem_ready never asserted, TIMEOUT_CYC=4 -> after 4 ACCESS cycles, ack and err_out pulse together, rdata=0, state returns to IDLE.
- Assert reset during ACCESS -> all outputs 0 immediately (async), no ack. After release, a pending if_req is granted normally.
- if_req dropped mid-ACCESS -> access completes and if_ack still pulses; no second access is started.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: 8-bit clear/increment counter; tc flags the last allowed ACCESS cycle.
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  // Count holds the number of ACCESS cycles already finished, so the
  // TIMEOUT_CYC-th cycle is the one where count == TIMEOUT_CYC-1.
  localparam logic [7:0] TERM = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_d, cnt_q;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise DM wins ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err_out,
  output logic              mem_en,
  output logic              mem_rw_out,
  output logic [ADDR_W-1:0] mem_address_out,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready
);

  state_e            state_d, state_q;
  grant_e            gnt_d, gnt_q;
  grant_e            winner;
  logic              if_ack_d, if_ack_q;
  logic              dm_ack_d, dm_ack_q;
  logic              err_d, err_q;
  logic              mem_en_d, mem_en_q;
  logic              mem_rw_d, mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_d, if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_d, dm_rdata_q;
  logic              timeout;

`ifdef MEM_ARB_RR_EN
  grant_e            last_d, last_q;
`endif

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q != ACCESS),
    .inc  (state_q == ACCESS),
    .tc   (timeout)
  );

  always_comb begin
    winner = dm_req ? GNT_DM : GNT_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      winner = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          gnt_d    = winner;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
`ifdef MEM_ARB_RR_EN
          last_d   = winner;
`endif
          if (winner == GNT_DM) begin
            mem_rw_d    = dm_rw;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_rw_d   = RW_READ;
            mem_addr_d = if_addr;
          end
        end
      end

      ACCESS: begin
        // mem_ready is checked first so a completion on the watchdog's last cycle still succeeds.
        if (mem_ready || timeout) begin
          mem_en_d = 1'b0;
          err_d    = !mem_ready;
          state_d  = DONE;
          if (gnt_q == GNT_DM) begin
            dm_ack_d = 1'b1;
            if (mem_rw_q == RW_READ) begin
              dm_rdata_d = mem_ready ? mem_data_in : '0;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ready ? mem_data_in : '0;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_q      <= GNT_IF;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign if_ack          = if_ack_q;
  assign if_rdata        = if_rdata_q;
  assign dm_ack          = dm_ack_q;
  assign dm_rdata        = dm_rdata_q;
  assign err_out         = err_q;
  assign mem_en          = mem_en_q;
  assign mem_rw_out      = mem_rw_q;
  assign mem_address_out = mem_addr_q;
  assign mem_data_out    = mem_wdata_q;

endmodule
